rggen_trigger_request: RTL and testbench
========================================

RGGEN_TRIGGER_REQUEST -- requirements
Module: rggen_trigger_request

Interface
REQ-001 SHALL have parameter WIDTH, default 1, number of independent trigger channels.
REQ-002 SHALL have parameter COUNT_WIDTH, default 4, width of each channel's pending-trigger counter.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_trigger  input  WIDTH  one-cycle trigger pulses from a write-0/1-trigger bit field.
REQ-006 SHALL have port o_request  output  WIDTH  per-channel level request to the downstream engine.
REQ-007 SHALL have port i_ack  input  WIDTH  per-channel acknowledge; consumes one pending trigger.
REQ-008 SHALL have port o_pending  output  WIDTH*COUNT_WIDTH  per-channel pending count; channel n occupies bits [n*COUNT_WIDTH +: COUNT_WIDTH].
REQ-009 SHALL have port o_overflow  output  WIDTH  per-channel sticky flag: a trigger was dropped.
REQ-010 SHALL have port i_overflow_clear  input  WIDTH  per-channel clear of o_overflow.

Function
REQ-011 Each channel SHALL operate independently; there is no cross-channel interaction.
REQ-012 Each channel SHALL hold an FSM with states IDLE (count 0) and PENDING (count > 0).
REQ-013 o_request[n] SHALL be 1 exactly when channel n is in PENDING; it is decoded from registered state with no combinational path from any input.
REQ-014 A handshake SHALL complete in a cycle where o_request[n]=1 and i_ack[n]=1.
REQ-015 i_ack[n] while o_request[n]=0 SHALL be ignored.
REQ-016 Trigger without handshake: count +1 on the next edge unless saturated.
REQ-017 Handshake without trigger: count -1 on the next edge.
REQ-018 Trigger and handshake in the same cycle: count unchanged, and the channel stays in PENDING.
REQ-019 Latency: a trigger in cycle N with count 0 SHALL give o_request=1 from cycle N+1.
REQ-020 A handshake in cycle N with count 1 and no trigger SHALL give o_request=0 from cycle N+1.
REQ-021 Back-to-back service: with count > 1, o_request SHALL stay 1 across a handshake, with no gap cycle.
REQ-022 Saturation: a trigger at count 2^COUNT_WIDTH-1 with no handshake SHALL leave count unchanged, drop the trigger and set o_overflow[n] on the next edge.
REQ-023 A trigger at saturation with a handshake SHALL follow REQ-018, with no overflow.
REQ-024 o_overflow[n] SHALL stay 1 until i_overflow_clear[n]=1, which clears it on the next edge.
REQ-025 If set and clear of o_overflow occur in the same cycle, set SHALL win.
REQ-026 Counter arithmetic SHALL be unsigned COUNT_WIDTH bits and SHALL never wrap in either direction.

Reset
REQ-027 Asserting i_rst SHALL immediately force every channel to IDLE, set counts to 0, o_request to 0, o_pending to 0 and o_overflow to 0, regardless of i_clk.
REQ-028 Reset mid-operation SHALL discard all pending triggers and outstanding requests.
REQ-029 Triggers or acks present while i_rst=1 SHALL have no effect.
REQ-030 On the first edge after deassertion, the channel SHALL obey REQ-016 to REQ-018 normally.

Structure
REQ-031 The per-channel FSM state enum (IDLE, PENDING) SHALL live in the shared package rggen_rtl_pkg as rggen_trigger_request_state_e.
REQ-032 Per-channel logic SHALL be the sub-module rggen_trigger_request_channel, instantiated WIDTH times by a generate loop.
REQ-033 The top level SHALL contain only the generate loop and the packing of o_pending.

Verification
REQ-034 Basic service: WIDTH=1, trigger at cycle 0, ack held high -> o_request=1 in cycle 1 only; o_pending = 1 then 0; o_overflow=0.
REQ-035 Queuing: 3 triggers on consecutive cycles, ack held low -> o_pending=3; then ack high for 3 cycles -> o_request stays 1 for exactly 3 cycles, then 0.
REQ-036 Simultaneous events: count 2, trigger and ack together -> o_pending stays 2 and o_request stays 1.
REQ-037 Saturation: COUNT_WIDTH=2, 5 triggers with no ack -> o_pending=3, o_overflow=1; set and clear in the same cycle -> o_overflow stays 1; a lone clear -> o_overflow=0.
REQ-038 Reset mid-operation: count 2 with o_overflow=1, i_rst asserted between clock edges -> all outputs 0 immediately; after release, one trigger -> o_pending=1.
REQ-039 Channel independence: WIDTH=4, trigger on 4'b0101, ack on 4'b1111 -> only channels 0 and 2 ever assert o_request; stray acks on channels 1 and 3 do not change state.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared package for the rggen RTL blocks.
// Holds the per-channel FSM state type used by rggen_trigger_request_channel.
package rggen_rtl_pkg;

  // IDLE    : no trigger is pending (count == 0)
  // PENDING : at least one trigger is waiting for service (count > 0)
  typedef enum logic {
    TRIGGER_REQUEST_IDLE    = 1'b0,
    TRIGGER_REQUEST_PENDING = 1'b1
  } rggen_trigger_request_state_e;

endpackage

// File: rtl/rggen_trigger_request_channel.sv
// One trigger-request channel.
// Counts one-cycle trigger pulses, raises a level request while any trigger
// is pending and consumes one pending trigger per request/ack handshake.
// A trigger that arrives while the counter is full and no handshake
// completes is dropped and recorded in a sticky overflow flag.
//
// Ports
//   i_clk            : clock, rising edge
//   i_rst            : asynchronous active-high reset
//   i_trigger        : one-cycle trigger pulse
//   i_ack            : acknowledge from the downstream engine
//   i_overflow_clear : clears o_overflow on the next edge
//   o_request        : level request, high while triggers are pending
//   o_pending        : number of pending triggers
//   o_overflow       : sticky flag, a trigger was dropped
module rggen_trigger_request_channel
  import rggen_rtl_pkg::*;
#(
  parameter int COUNT_WIDTH = 4
)(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_trigger,
  input  logic                   i_ack,
  input  logic                   i_overflow_clear,
  output logic                   o_request,
  output logic [COUNT_WIDTH-1:0] o_pending,
  output logic                   o_overflow
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  rggen_trigger_request_state_e state;
  rggen_trigger_request_state_e state_next;
  logic [COUNT_WIDTH-1:0]       count;
  logic [COUNT_WIDTH-1:0]       count_next;
  logic                         overflow;
  logic                         overflow_next;
  logic                         handshake;

  // The request is a pure decode of the registered state, so there is no
  // combinational path from any input to o_request.
  assign o_request  = (state == TRIGGER_REQUEST_PENDING);
  assign o_pending  = count;
  assign o_overflow = overflow;

  // An ack only counts while the request is actually raised.
  assign handshake  = o_request && i_ack;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= TRIGGER_REQUEST_IDLE;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      overflow <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state;
    count_next    = count;
    overflow_next = overflow;

    // Clear first so that a simultaneous set below takes priority.
    if (i_overflow_clear) begin
      overflow_next = 1'b0;
    end

    unique case (state)
      TRIGGER_REQUEST_IDLE: begin
        if (i_trigger) begin
          count_next = COUNT_ONE;
          state_next = TRIGGER_REQUEST_PENDING;
        end
      end
      TRIGGER_REQUEST_PENDING: begin
        if (i_trigger && !handshake) begin
          if (count == COUNT_MAX) begin
            overflow_next = 1'b1;
          end else begin
            count_next = count + COUNT_ONE;
          end
        end else if (handshake && !i_trigger) begin
          count_next = count - COUNT_ONE;
          if (count == COUNT_ONE) begin
            state_next = TRIGGER_REQUEST_IDLE;
          end
        end
        // Trigger together with a handshake: one in, one out, no change.
      end
      default: begin
        state_next = TRIGGER_REQUEST_IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/rggen_trigger_request.sv
// Multi-channel trigger-request block.
// Instantiates WIDTH independent trigger-request channels and packs their
// pending counts into o_pending (channel n at [n*COUNT_WIDTH +: COUNT_WIDTH]).
//
// Ports
//   i_clk            : clock, rising edge
//   i_rst            : asynchronous active-high reset
//   i_trigger        : per-channel one-cycle trigger pulses
//   o_request        : per-channel level request
//   i_ack            : per-channel acknowledge
//   o_pending        : packed per-channel pending counts
//   o_overflow       : per-channel sticky dropped-trigger flag
//   i_overflow_clear : per-channel clear of o_overflow
module rggen_trigger_request
  import rggen_rtl_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int COUNT_WIDTH = 4
)(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [WIDTH-1:0]             i_trigger,
  output logic [WIDTH-1:0]             o_request,
  input  logic [WIDTH-1:0]             i_ack,
  output logic [WIDTH*COUNT_WIDTH-1:0] o_pending,
  output logic [WIDTH-1:0]             o_overflow,
  input  logic [WIDTH-1:0]             i_overflow_clear
);

  logic [COUNT_WIDTH-1:0] pending [WIDTH];

  for (genvar g = 0; g < WIDTH; g++) begin : g_channel
    rggen_trigger_request_channel #(
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_channel (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_trigger        (i_trigger[g]),
      .i_ack            (i_ack[g]),
      .i_overflow_clear (i_overflow_clear[g]),
      .o_request        (o_request[g]),
      .o_pending        (pending[g]),
      .o_overflow       (o_overflow[g])
    );

    assign o_pending[g*COUNT_WIDTH +: COUNT_WIDTH] = pending[g];
  end

endmodule

// File: tb/tb_rggen_trigger_request.sv
module tb_rggen_trigger_request;

  localparam int W   = 4;
  localparam int CW  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic            clk;
  logic            rst;
  logic [W-1:0]    trig;
  logic [W-1:0]    req;
  logic [W-1:0]    ack;
  logic [W*CW-1:0] pend;
  logic [W-1:0]    ovf;
  logic [W-1:0]    clr;

  rggen_trigger_request #(
    .WIDTH       (W),
    .COUNT_WIDTH (CW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_trigger        (trig),
    .o_request        (req),
    .i_ack            (ack),
    .o_pending        (pend),
    .o_overflow       (ovf),
    .i_overflow_clear (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [W-1:0]    req;
    logic [W*CW-1:0] pend;
    logic [W-1:0]    ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: pending count and overflow flag per channel.
  int cnt [W];
  bit ov  [W];

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d actual %h required %h", nm, c, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < W; i++) begin
      cnt[i] = 0;
      ov[i]  = 1'b0;
    end
  endfunction

  function automatic exp_t model_out(input int c);
    exp_t e;
    e.cyc  = c;
    e.req  = '0;
    e.pend = '0;
    e.ovf  = '0;
    for (int i = 0; i < W; i++) begin
      e.req[i]            = (cnt[i] > 0);
      e.pend[i*CW +: CW]  = CW'(cnt[i]);
      e.ovf[i]            = ov[i];
    end
    return e;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  function automatic void model_edge(input bit r, input logic [W-1:0] t,
                                     input logic [W-1:0] a, input logic [W-1:0] c);
    if (r) begin
      model_reset();
      return;
    end
    for (int i = 0; i < W; i++) begin
      bit hs;
      bit drop;
      hs   = (cnt[i] > 0) && a[i];
      drop = t[i] && !hs && (cnt[i] == MAX);
      if (t[i] && !hs && cnt[i] < MAX) cnt[i] = cnt[i] + 1;
      else if (hs && !t[i])            cnt[i] = cnt[i] - 1;
      if (drop)      ov[i] = 1'b1;
      else if (c[i]) ov[i] = 1'b0;
    end
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue the state the
  // DUT must show after the following rising edge.
  task automatic step(input bit r, input logic [W-1:0] t,
                      input logic [W-1:0] a, input logic [W-1:0] c);
    @(negedge clk);
    rst  = r;
    trig = t;
    ack  = a;
    clr  = c;
    cyc++;
    model_edge(r, t, a, c);
    q.push_back(model_out(cyc));
  endtask

  // Assert reset between edges and check that outputs clear at once.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst  = 1'b1;
    trig = 4'($urandom);
    ack  = 4'($urandom);
    #1;
    chk("async_rst_req",  cyc, 32'(req),  32'd0);
    chk("async_rst_pend", cyc, 32'(pend), 32'd0);
    chk("async_rst_ovf",  cyc, 32'(ovf),  32'd0);
    model_reset();
  endtask

  // Monitor: compare queued expectations with the DUT after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("request", e.cyc, 32'(req),  32'(e.req));
        chk("pending", e.cyc, 32'(pend), 32'(e.pend));
        chk("overflow", e.cyc, 32'(ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d actual timeout required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    trig = '0;
    ack  = '0;
    clr  = '0;
    model_reset();
    #1;
    chk("reset_req",  0, 32'(req),  32'd0);
    chk("reset_pend", 0, 32'(pend), 32'd0);
    chk("reset_ovf",  0, 32'(ovf),  32'd0);
    step(1, 4'h1, 4'h0, 4'h0);   // trigger during reset is ignored
    step(0, 4'h0, 4'h0, 4'h0);

    // Basic service: trigger with ack held high.
    step(0, 4'h1, 4'h1, 4'h0);
    step(0, 4'h0, 4'h1, 4'h0);
    step(0, 4'h0, 4'h1, 4'h0);
    step(0, 4'h0, 4'h0, 4'h0);

    // Queuing: three triggers, then three acks.
    repeat (3) step(0, 4'h1, 4'h0, 4'h0);
    repeat (3) step(0, 4'h0, 4'h1, 4'h0);
    step(0, 4'h0, 4'h0, 4'h0);

    // Simultaneous trigger and ack at count 2.
    repeat (2) step(0, 4'h1, 4'h0, 4'h0);
    step(0, 4'h1, 4'h1, 4'h0);
    repeat (3) step(0, 4'h0, 4'h1, 4'h0);

    // Saturation, set-vs-clear priority, lone clear.
    repeat (5) step(0, 4'h1, 4'h0, 4'h0);
    step(0, 4'h1, 4'h0, 4'h1);
    step(0, 4'h0, 4'h0, 4'h0);
    step(0, 4'h0, 4'h0, 4'h1);
    step(0, 4'h1, 4'h1, 4'h0);   // trigger + ack at saturation, no overflow
    step(0, 4'h0, 4'h0, 4'h0);

    // Reset mid-operation with count 2 and overflow set.
    repeat (4) step(0, 4'h1, 4'h0, 4'h0);
    step(0, 4'h0, 4'h1, 4'h0);
    async_reset();
    step(1, 4'hF, 4'hF, 4'h0);
    step(0, 4'h0, 4'h0, 4'h0);
    step(0, 4'h1, 4'h0, 4'h0);
    step(0, 4'h0, 4'h0, 4'h0);
    repeat (2) step(0, 4'h0, 4'h1, 4'h0);

    // Channel independence: stray acks on idle channels.
    step(0, 4'b0101, 4'b1111, 4'h0);
    repeat (3) step(0, 4'h0, 4'b1111, 4'h0);
    step(0, 4'b1010, 4'b0000, 4'h0);
    step(0, 4'b0000, 4'b0101, 4'h0);
    repeat (3) step(0, 4'h0, 4'b1111, 4'h0);

    // Randomized traffic with occasional clears and resets.
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] t;
      logic [W-1:0] a;
      logic [W-1:0] c;
      t = 4'($urandom);
      a = 4'($urandom) & 4'($urandom);
      c = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        step(1, t, a, c);
      end else begin
        step(0, t, a, c);
      end
    end
    step(0, 4'h0, 4'h0, 4'h0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    chk("queue_drain", cyc, 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
